// File: rtl/ws2811_pkg.sv
// Shared types and constants for the WS2811 frame serializer.
// Macro WS2811_GRB_ORDER_EN selects G,R,B transmit order instead of R,G,B.
package ws2811_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        LATCH
    } state_t;

    localparam int T0H_DEFAULT   = 20;
    localparam int T1H_DEFAULT   = 40;
    localparam int BIT_DEFAULT   = 63;
    localparam int LATCH_DEFAULT = 3000;

    localparam int MAX_LEDS      = 5;
    localparam int BITS_PER_LED  = 24;
    localparam int CYCLE_CNT_W   = 12;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    // Rearranges a {R,G,B} word so that bit 23 is always the first bit on the wire.
    function automatic logic [23:0] tx_order(input logic [23:0] word);
`ifdef WS2811_GRB_ORDER_EN
        return {word[G_LSB +: 8], word[R_LSB +: 8], word[B_LSB +: 8]};
`else
        return word;
`endif
    endfunction

    function automatic logic [2:0] clamp_count(input logic [7:0] count);
        return (count > 8'(MAX_LEDS)) ? 3'(MAX_LEDS) : count[2:0];
    endfunction

endpackage

// File: rtl/ws2811_frame_serializer_if.sv
// Colour-word inputs and serial/status outputs of the WS2811 frame serializer.
interface ws2811_frame_serializer_if;
    logic        enable;
    logic [7:0]  led_count;
    logic [23:0] led0;
    logic [23:0] led1;
    logic [23:0] led2;
    logic [23:0] led3;
    logic [23:0] led4;
    logic        serial;
    logic        db_serial;
    logic        busy;
    logic        frame_done;

    modport master (
        output enable, led_count, led0, led1, led2, led3, led4,
        input  serial, db_serial, busy, frame_done
    );

    modport slave (
        input  enable, led_count, led0, led1, led2, led3, led4,
        output serial, db_serial, busy, frame_done
    );
endinterface

// File: rtl/ws2811_bit_timer.sv
// Generates one NRZ bit slot: line high for the T0H/T1H time, low for the rest of BIT_CYCLES.
module ws2811_bit_timer
    import ws2811_pkg::*;
#(
    parameter int T0H_CYCLES = T0H_DEFAULT,
    parameter int T1H_CYCLES = T1H_DEFAULT,
    parameter int BIT_CYCLES = BIT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic bit_value,
    output logic line,
    output logic line_copy,
    output logic high_done,
    output logic bit_done
);

    localparam int CW = $clog2(BIT_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] hi_len;
    logic          active;

    // Both strobes fire in the last cycle of their phase so a new slot can start on the same edge.
    assign high_done = active && line && (cnt == hi_len - CW'(1));
    assign bit_done  = active && (cnt == CW'(BIT_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            hi_len    <= '0;
            active    <= 1'b0;
            line      <= 1'b0;
            line_copy <= 1'b0;
        end else if (start) begin
            cnt       <= '0;
            hi_len    <= bit_value ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES);
            active    <= 1'b1;
            line      <= 1'b1;
            line_copy <= 1'b1;
        end else if (active) begin
            cnt <= cnt + CW'(1);
            if (high_done) begin
                line      <= 1'b0;
                line_copy <= 1'b0;
            end
            if (bit_done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ws2811_frame_serializer.sv
// Snapshots up to five LED words and streams them as a WS2811 frame followed by a latch gap.
// Macro WS2811_GRB_ORDER_EN (see ws2811_pkg) switches per-LED byte order to G,R,B.
module ws2811_frame_serializer
    import ws2811_pkg::*;
#(
    parameter int T0H_CYCLES   = T0H_DEFAULT,
    parameter int T1H_CYCLES   = T1H_DEFAULT,
    parameter int BIT_CYCLES   = BIT_DEFAULT,
    parameter int LATCH_CYCLES = LATCH_DEFAULT
) (
    input logic                      clock,
    input logic                      reset,
    ws2811_frame_serializer_if.slave bus
);

    state_t                 state;
    logic [23:0]            shadow [MAX_LEDS];
    logic [2:0]             count_q;
    logic [4:0]             bit_idx;
    logic [2:0]             led_idx;
    logic [CYCLE_CNT_W-1:0] latch_cnt;
    logic                   busy_q;
    logic                   frame_done_q;

    logic [2:0]  count_in;
    logic        start_frame;
    logic        last_bit;
    logic [4:0]  bit_next;
    logic [2:0]  led_next;
    logic [23:0] word_sel;
    logic [23:0] first_word;
    logic [23:0] next_word;
    logic        timer_start;
    logic        timer_bit;
    logic        line;
    logic        line_copy;
    logic        high_done;
    logic        bit_done;

    assign count_in    = clamp_count(bus.led_count);
    assign start_frame = (state == IDLE) && bus.enable && (count_in != 3'd0);
    assign last_bit    = (bit_idx == 5'(BITS_PER_LED - 1)) && (led_idx == count_q - 3'd1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        bit_next = bit_idx + 5'd1;
        led_next = led_idx;
        if (bit_idx == 5'(BITS_PER_LED - 1)) begin
            bit_next = '0;
            led_next = led_idx + 3'd1;
        end
    end

    always_comb begin
        word_sel = '0;
        case (led_next)
            3'd0:    word_sel = shadow[0];
            3'd1:    word_sel = shadow[1];
            3'd2:    word_sel = shadow[2];
            3'd3:    word_sel = shadow[3];
            3'd4:    word_sel = shadow[4];
            default: word_sel = '0;
        endcase
    end

    // The first bit comes straight from led0 so serial rises on the capture edge itself.
    assign first_word  = tx_order(bus.led0);
    assign next_word   = tx_order(word_sel);
    assign timer_start = start_frame || ((state == LOW) && bit_done && !last_bit);
    assign timer_bit   = start_frame ? first_word[23] : next_word[5'd23 - bit_next];

    ws2811_bit_timer #(
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES),
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clock     (clock),
        .reset     (reset),
        .start     (timer_start),
        .bit_value (timer_bit),
        .line      (line),
        .line_copy (line_copy),
        .high_done (high_done),
        .bit_done  (bit_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count_q      <= '0;
            bit_idx      <= '0;
            led_idx      <= '0;
            latch_cnt    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            // NOTE: the shadow words are only five registers, so they are cleared rather than left unknown.
            for (int i = 0; i < MAX_LEDS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start_frame) begin
                        shadow[0] <= bus.led0;
                        shadow[1] <= bus.led1;
                        shadow[2] <= bus.led2;
                        shadow[3] <= bus.led3;
                        shadow[4] <= bus.led4;
                        count_q   <= count_in;
                        bit_idx   <= '0;
                        led_idx   <= '0;
                        busy_q    <= 1'b1;
                        state     <= HIGH;
                    end
                end
                HIGH: begin
                    if (high_done) begin
                        state <= LOW;
                    end
                end
                LOW: begin
                    if (bit_done) begin
                        if (last_bit) begin
                            latch_cnt <= '0;
                            state     <= LATCH;
                        end else begin
                            bit_idx <= bit_next;
                            led_idx <= led_next;
                            state   <= HIGH;
                        end
                    end
                end
                LATCH: begin
                    latch_cnt <= latch_cnt + CYCLE_CNT_W'(1);
                    // frame_done is raised for exactly the final latch cycle.
                    if (latch_cnt == CYCLE_CNT_W'(LATCH_CYCLES - 2)) begin
                        frame_done_q <= 1'b1;
                    end
                    if (latch_cnt == CYCLE_CNT_W'(LATCH_CYCLES - 1)) begin
                        frame_done_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.serial     = line;
    assign bus.db_serial  = line_copy;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule
